// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-zone alarm controller.
//   state_t : FSM state encodings (IDLE=0 .. ALARM=4)
//   max3    : largest of three values, used to size the delay counter
package alarm_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_EXIT  = 3'd1,
        ST_ARMED = 3'd2,
        ST_ENTRY = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk, rst_n : clock, async active-low reset (flops clear to 0)
//   d          : asynchronous input vector
//   q          : synchronised output vector
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm supervisor: exit/entry delays, timed or latching alarm,
// sticky record of tripping zones.
//   clk, rst_n  : clock, async active-low reset
//   arm, disarm : level-sampled requests (disarm has priority)
//   zone_en     : per-zone enable
//   sensor      : raw asynchronous sensor levels
//   alarm, armed, pending, ready : status decoded from registered state
//   trip_zones  : zones that caused ENTRY or ALARM since the last arm
//   state_o     : current state encoding
module alarm_zone_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned              NUM_ZONES    = 4,
    parameter logic [NUM_ZONES-1:0]     INSTANT_MASK = NUM_ZONES'(1),
    parameter int unsigned              EXIT_CYCLES  = 32,
    parameter int unsigned              ENTRY_CYCLES = 16,
    parameter int unsigned              ALARM_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic [NUM_ZONES-1:0] zone_en,
    input  logic [NUM_ZONES-1:0] sensor,
    output logic                 alarm,
    output logic                 armed,
    output logic                 pending,
    output logic                 ready,
    output logic [NUM_ZONES-1:0] trip_zones,
    output logic [STATE_W-1:0]   state_o
);

    localparam int unsigned CNT_W      = $clog2(max3(EXIT_CYCLES, ENTRY_CYCLES, ALARM_CYCLES) + 1);
    localparam int unsigned EXIT_LOAD  = EXIT_CYCLES - 1;
    localparam int unsigned ENTRY_LOAD = ENTRY_CYCLES - 1;
    // A zero alarm length latches; the counter is parked at 0 and ignored.
    localparam int unsigned ALARM_LOAD = (ALARM_CYCLES == 0) ? 0 : ALARM_CYCLES - 1;

    logic [NUM_ZONES-1:0] s_q;
    logic [NUM_ZONES-1:0] act;
    logic                 instant_hit;
    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [NUM_ZONES-1:0] trip_d;

    sync_2ff #(.WIDTH(NUM_ZONES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sensor),
        .q     (s_q)
    );

    assign act         = s_q & zone_en;
    assign instant_hit = |(act & INSTANT_MASK);

    // State, delay counter and trip record registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            trip_zones <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            trip_zones <= trip_d;
        end
    end

    // Next-state, counter and trip-record logic
    always_comb begin
        state_d = state;
        cnt_d   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        trip_d  = trip_zones;

        case (state)
            ST_IDLE: begin
                if (arm && !disarm && ready) begin
                    state_d = ST_EXIT;
                    cnt_d   = CNT_W'(EXIT_LOAD);
                    trip_d  = '0;
                end
            end
            ST_EXIT: begin
                if (cnt == '0) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (instant_hit) begin
                    state_d = ST_ALARM;
                    cnt_d   = CNT_W'(ALARM_LOAD);
                    trip_d  = trip_zones | act;
                end else if (|act) begin
                    state_d = ST_ENTRY;
                    cnt_d   = CNT_W'(ENTRY_LOAD);
                    trip_d  = trip_zones | act;
                end
            end
            ST_ENTRY: begin
                trip_d = trip_zones | act;
                if (instant_hit || cnt == '0) begin
                    state_d = ST_ALARM;
                    cnt_d   = CNT_W'(ALARM_LOAD);
                end
            end
            ST_ALARM: begin
                trip_d = trip_zones | act;
                if (ALARM_CYCLES != 0 && cnt == '0) begin
                    state_d = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Disarm overrides everything but keeps the trip record for display.
        if (disarm) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            trip_d  = trip_zones;
        end
    end

    assign alarm   = (state == ST_ALARM);
    assign armed   = (state == ST_ARMED) || (state == ST_ENTRY) || (state == ST_ALARM);
    assign pending = (state == ST_EXIT) || (state == ST_ENTRY);
    assign ready   = ~|act;
    assign state_o = state;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Directed bench for alarm_zone_ctrl: default instance (timed alarm) plus a
// latching-alarm instance sharing the same inputs.
module tb_alarm_zone_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arm, disarm;
    logic [3:0] zone_en, sensor;

    logic       alarm, armed, pending, ready;
    logic [3:0] trip_zones;
    logic [2:0] state_o;

    logic       l_alarm, l_armed, l_pending, l_ready;
    logic [3:0] l_trip;
    logic [2:0] l_state;

    int errors = 0;
    int checks = 0;

    alarm_zone_ctrl dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm),
        .zone_en(zone_en), .sensor(sensor),
        .alarm(alarm), .armed(armed), .pending(pending), .ready(ready),
        .trip_zones(trip_zones), .state_o(state_o)
    );

    alarm_zone_ctrl #(.ALARM_CYCLES(0)) dut_latch (
        .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm),
        .zone_en(zone_en), .sensor(sensor),
        .alarm(l_alarm), .armed(l_armed), .pending(l_pending), .ready(l_ready),
        .trip_zones(l_trip), .state_o(l_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm_and_exit();
        int n;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n = 0;
        while (pending === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != 32 || state_o !== 3'd2) begin
            errors++;
            $display("FAIL arm_exit: pending_cycles=%0d state=%0d, required 32 and 2", n, state_o);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({alarm, armed, pending, ready, trip_zones, state_o} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_vals: got a=%b ar=%b p=%b r=%b t=%b s=%0d", alarm, armed, pending, ready, trip_zones, state_o);
        end
    endtask

    task automatic test_arm_exit();
        int n;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (state_o !== 3'd1 || pending !== 1'b1 || armed !== 1'b0) begin
            errors++;
            $display("FAIL exit_entered: state=%0d pending=%b armed=%b, required 1 1 0", state_o, pending, armed);
        end
        n = 0;
        while (pending === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL exit_length: %0d cycles, required 32", n);
        end
        checks++;
        if (state_o !== 3'd2 || armed !== 1'b1) begin
            errors++;
            $display("FAIL armed_after_exit: state=%0d armed=%b, required 2 1", state_o, armed);
        end
    endtask

    task automatic test_entry_timeout();
        int n;
        sensor = 4'b0100;
        tick();
        tick();
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL entry_latency_early: state=%0d, required 2", state_o);
        end
        tick();
        checks++;
        if (state_o !== 3'd3 || pending !== 1'b1 || trip_zones !== 4'b0100) begin
            errors++;
            $display("FAIL entry_entered: state=%0d pending=%b trip=%b, required 3 1 0100", state_o, pending, trip_zones);
        end
        n = 0;
        while (state_o === 3'd3 && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != 16 || alarm !== 1'b1 || state_o !== 3'd4) begin
            errors++;
            $display("FAIL entry_timeout: entry_cycles=%0d alarm=%b state=%0d, required 16 1 4", n, alarm, state_o);
        end
        checks++;
        if (trip_zones !== 4'b0100 || l_trip !== 4'b0100) begin
            errors++;
            $display("FAIL entry_trip: trip=%b latch_trip=%b, required 0100", trip_zones, l_trip);
        end
        sensor = 4'b0000;
    endtask

    task automatic test_timed_alarm();
        int n;
        n = 1;
        tick();
        while (alarm === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        checks++;
        if (n != 64 || state_o !== 3'd2 || armed !== 1'b1) begin
            errors++;
            $display("FAIL timed_alarm: alarm_cycles=%0d state=%0d armed=%b, required 64 2 1", n, state_o, armed);
        end
        repeat (40) tick();
        checks++;
        if (l_alarm !== 1'b1 || l_state !== 3'd4 || state_o !== 3'd2) begin
            errors++;
            $display("FAIL latch_alarm: latch_alarm=%b latch_state=%0d state=%0d, required 1 4 2", l_alarm, l_state, state_o);
        end
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        checks++;
        if (state_o !== 3'd0 || l_state !== 3'd0 || l_alarm !== 1'b0 || armed !== 1'b0 ||
            trip_zones !== 4'b0100 || l_trip !== 4'b0100) begin
            errors++;
            $display("FAIL disarm_hold: state=%0d lstate=%0d lalarm=%b armed=%b trip=%b ltrip=%b, required 0 0 0 0 0100 0100",
                     state_o, l_state, l_alarm, armed, trip_zones, l_trip);
        end
    endtask

    task automatic test_instant();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (trip_zones !== 4'b0000 || state_o !== 3'd1) begin
            errors++;
            $display("FAIL arm_clears_trip: trip=%b state=%0d, required 0000 1", trip_zones, state_o);
        end
        repeat (32) tick();
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL instant_armed: state=%0d, required 2", state_o);
        end
        sensor = 4'b0001;
        tick();
        tick();
        checks++;
        if (state_o !== 3'd2 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL instant_early: state=%0d alarm=%b, required 2 0", state_o, alarm);
        end
        tick();
        checks++;
        if (state_o !== 3'd4 || alarm !== 1'b1 || trip_zones !== 4'b0001) begin
            errors++;
            $display("FAIL instant_alarm: state=%0d alarm=%b trip=%b, required 4 1 0001", state_o, alarm, trip_zones);
        end
        disarm = 1'b1;
        sensor = 4'b0000;
        tick();
        disarm = 1'b0;
        tick();
        tick();
        checks++;
        if (state_o !== 3'd0 || ready !== 1'b1 || trip_zones !== 4'b0001) begin
            errors++;
            $display("FAIL instant_disarm: state=%0d ready=%b trip=%b, required 0 1 0001", state_o, ready, trip_zones);
        end
    endtask

    task automatic test_disarm_priority();
        do_arm_and_exit();
        sensor = 4'b0100;
        repeat (3) tick();
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL prio_entry: state=%0d, required 3", state_o);
        end
        disarm = 1'b1;
        sensor = 4'b0101;
        arm    = 1'b1;
        tick();
        disarm = 1'b0;
        arm    = 1'b0;
        checks++;
        if (state_o !== 3'd0 || alarm !== 1'b0 || trip_zones !== 4'b0100) begin
            errors++;
            $display("FAIL disarm_priority: state=%0d alarm=%b trip=%b, required 0 0 0100", state_o, alarm, trip_zones);
        end
        repeat (3) tick();
        checks++;
        if (state_o !== 3'd0 || alarm !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL disarm_stays_idle: state=%0d alarm=%b ready=%b, required 0 0 0", state_o, alarm, ready);
        end
        sensor = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_not_ready_mask();
        sensor = 4'b0010;
        tick();
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL not_ready: ready=%b, required 0", ready);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL arm_not_ready: state=%0d, required 0", state_o);
        end
        zone_en = 4'b1101;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL masked_ready: ready=%b, required 1", ready);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checks++;
        if (state_o !== 3'd1 || pending !== 1'b1) begin
            errors++;
            $display("FAIL masked_arm: state=%0d pending=%b, required 1 1", state_o, pending);
        end
        repeat (32) tick();
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL masked_zone_ignored: state=%0d, required 2", state_o);
        end
        disarm = 1'b1;
        tick();
        disarm  = 1'b0;
        sensor  = 4'b0000;
        zone_en = 4'b1111;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_alarm();
        do_arm_and_exit();
        sensor = 4'b0001;
        repeat (3) tick();
        checks++;
        if (alarm !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_alarm: alarm=%b, required 1", alarm);
        end
        #2;
        rst_n  = 1'b0;
        sensor = 4'b0000;
        #1;
        checks++;
        if ({alarm, armed, pending, ready, trip_zones, state_o} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'b0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: got a=%b ar=%b p=%b r=%b t=%b s=%0d", alarm, armed, pending, ready, trip_zones, state_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (state_o !== 3'd0 || pending !== 1'b0 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: state=%0d pending=%b alarm=%b, required 0 0 0", state_o, pending, alarm);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        arm     = 1'b0;
        disarm  = 1'b0;
        zone_en = 4'b1111;
        sensor  = 4'b0000;
        #22;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_arm_exit();
        test_entry_timeout();
        test_timed_alarm();
        test_instant();
        test_disarm_priority();
        test_not_ready_mask();
        test_reset_mid_alarm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_zone_ctrl.md
# alarm_zone_ctrl

Multi-zone successor to the single-sensor security FSM. It supervises `NUM_ZONES` sensor inputs with per-zone enable and instant/delayed classification. The block adds exit and entry delays, a timed or latching alarm, and a tripped-zone record. It sits between the raw sensor pins and the top-level alarm output, and it exposes its state for the display logic.

## Interface
Parameters:
- `NUM_ZONES`, 4: number of sensor zones, 1..8.
- `INSTANT_MASK`, 4'b0001: bit i = 1 makes zone i an instant zone, which skips the entry delay.
- `EXIT_CYCLES`, 32: exit delay length in cycles, at least 1.
- `ENTRY_CYCLES`, 16: entry delay length in cycles, at least 1.
- `ALARM_CYCLES`, 64: alarm duration in cycles. 0 means the alarm latches until disarm.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `arm` in 1: arm request, level-sampled.
- `disarm` in 1: disarm request, level-sampled.
- `zone_en` in `NUM_ZONES`: per-zone enable. A disabled zone is ignored completely.
- `sensor` in `NUM_ZONES`: raw asynchronous sensor levels, active-high.
- `alarm` out 1: high while in ALARM.
- `armed` out 1: high in ARMED, ENTRY and ALARM.
- `pending` out 1: high in EXIT and ENTRY.
- `ready` out 1: no enabled zone is active (synchronised value).
- `trip_zones` out `NUM_ZONES`: sticky record of the zones that caused ENTRY or ALARM.
- `state_o` out 3: current state encoding.

## Operation
- **Input synchronisation:** `sensor` passes through a 2-flop synchroniser to give `s_q`.
- **Active set:** `act = s_q & zone_en`.
- **States:** IDLE=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4. Encodings 5–7 are illegal and go to IDLE.
- **IDLE:**
  - `arm & !disarm & ready` → EXIT; clear `trip_zones`.
  - `arm` while `!ready` is ignored.
- **EXIT:** sensors are ignored. After `EXIT_CYCLES` cycles → ARMED.
- **ARMED:**
  - Any `act & INSTANT_MASK` → ALARM.
  - Otherwise, any delayed zone in `act` → ENTRY.
  - In both cases, OR `act` into `trip_zones`.
- **ENTRY:**
  - After `ENTRY_CYCLES` cycles → ALARM.
  - An instant zone becoming active → ALARM immediately.
  - Keep OR-ing `act` into `trip_zones`.
- **ALARM:**
  - If `ALARM_CYCLES` > 0: after `ALARM_CYCLES` cycles → ARMED (re-arm). A zone still active re-triggers from ARMED on the next cycle (level-sensitive).
  - Keep OR-ing `act` into `trip_zones`.
- **Disarm:** `disarm` in any state → IDLE on the next edge. Disarm beats arm and beats sensor events in the same cycle.
- **Arm outside IDLE:** ignored.
- **`trip_zones` lifetime:** held through disarm; cleared only by an accepted arm or by reset.
- **Delay counter:** one shared down-counter.
  - Width is `$clog2(max(EXIT_CYCLES, ENTRY_CYCLES, ALARM_CYCLES)+1)`.
  - Loaded with N-1 on the transition into a timed state, decremented each cycle.
  - The transition fires on the edge where the counter equals 0, so the state lasts exactly N cycles.
- **Reset values:**
  - State IDLE, counter 0, `trip_zones` 0, synchroniser flops 0.
  - `alarm`=0, `armed`=0, `pending`=0, `ready`=1, `state_o`=0.

## Timing
- All outputs are Moore outputs decoded from registered state, or direct register outputs.
- Sensor latency:
  - Edge 0: `sensor` is set up before it.
  - Edge 1: `s_q` goes high.
  - Edge 2: the state changes and the outputs reflect it.
  - Total: 2 cycles.
- `arm` or `disarm` sampled at edge n → new state visible after edge n.
- `ready` lags `sensor` by 2 cycles. `trip_zones` updates on the same edge as the state change.
- Assertion of `rst_n` mid-delay clears everything asynchronously. After release the block starts in IDLE with no residual count.

## Structure
- Package `alarm_pkg`:
  - State enum and its encodings.
  - A `max3` function for counter sizing.
- Sub-module `sync_2ff`, width-parameterised and instantiated once with width `NUM_ZONES`.
- The remainder is a single FSM, counter and trip register in `alarm_zone_ctrl`.

## Test plan
All scenarios use default parameters.
- **Arm/exit:** zones idle, `arm` pulse → `pending`=1 for exactly 32 cycles, then `state_o`=2, `armed`=1.
- **Entry timeout:** ARMED, `sensor`[2]=1 → `state_o`=3 two cycles later, `alarm`=1 exactly 16 cycles after that, `trip_zones`=4'b0100.
- **Instant zone:** ARMED, `sensor`[0]=1 → `alarm`=1 two cycles later, no ENTRY state, `trip_zones`=4'b0001.
- **Disarm priority:** during ENTRY, `disarm`=1 together with `sensor`[0]=1 → IDLE, `alarm` stays 0, `trip_zones` retained.
- **Not ready and masking:** IDLE, `sensor`[1]=1, `zone_en`=4'b1111, `arm` → stays IDLE. With `zone_en`[1]=0 and `arm` → EXIT.
- **Timed alarm and reset:** with `ALARM_CYCLES`=64, `alarm` falls after 64 cycles and the state returns to 2. With `ALARM_CYCLES`=0, the alarm holds until `disarm`. `rst_n` low mid-ALARM → all outputs return to reset values immediately.
